// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter and sequencer sharing one ula between two
// requesters. One operation is in flight at a time:
// accept (OCIOSO) -> evaluate (EXEC) -> hold the response (RESP).
// Operands and selector going to the ula are registered. They change only on an
// accepting edge or on reset, so the combinational ula output is stable during EXEC.
module ula_arbitro #(
  parameter int   LARG     = 8,
  parameter logic PRIO_INI = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [3:0]      req_sel0,
  input  logic [3:0]      req_sel1,
  input  logic [LARG-1:0] req_a0,
  input  logic [LARG-1:0] req_a1,
  input  logic [LARG-1:0] req_b0,
  input  logic [LARG-1:0] req_b1,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [LARG-1:0] resp_s,
  output logic            resp_err,
  output logic [LARG-1:0] ula_a,
  output logic [LARG-1:0] ula_b,
  output logic [3:0]      ula_sel,
  input  logic [LARG-1:0] ula_s
);

  // FSM encoding
  localparam logic [1:0] OCIOSO = 2'b00;
  localparam logic [1:0] EXEC   = 2'b01;
  localparam logic [1:0] RESP   = 2'b10;

  // Selector codes from this value upward are not defined operations of the ula
  localparam logic [3:0] SEL_INVALID_MIN = 4'b1010;

  // Returns the one-hot response/ready vector for a requester index
  function automatic logic [1:0] port_onehot(input logic idx);
    port_onehot = idx ? 2'b10 : 2'b01;
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic            prio_r;       // requester that wins under contention
  logic            grant_r;      // requester owning the in-flight operation
  logic            win_s;        // winner of the current idle cycle
  logic            win_ok_s;     // an operation is accepted this cycle
  logic [1:0]      ready_s;
  logic [3:0]      win_sel_s;
  logic [LARG-1:0] win_a_s;
  logic [LARG-1:0] win_b_s;
  logic            resp_done_s;  // granted requester consumes the response

  logic [LARG-1:0] ula_a_r;
  logic [LARG-1:0] ula_b_r;
  logic [3:0]      ula_sel_r;
  logic [LARG-1:0] resp_s_r;
  logic            resp_err_r;
  logic [1:0]      resp_valid_r;

  // Grant selection: a lone requester wins outright; under contention the pointer decides
  always_comb begin
    win_s    = 1'b0;
    win_ok_s = 1'b0;
    ready_s  = 2'b00;
    if (state_r == OCIOSO) begin
      case (req_valid)
        2'b01: begin
          win_s    = 1'b0;
          win_ok_s = 1'b1;
        end
        2'b10: begin
          win_s    = 1'b1;
          win_ok_s = 1'b1;
        end
        2'b11: begin
          win_s    = prio_r;
          win_ok_s = 1'b1;
        end
        default: begin
          win_s    = 1'b0;
          win_ok_s = 1'b0;
        end
      endcase
      if (win_ok_s) begin
        ready_s = port_onehot(win_s);
      end else begin
        ready_s = 2'b00;
      end
    end else begin
      win_ok_s = 1'b0;
      ready_s  = 2'b00;
    end
  end

  // Operand mux: forward the winner's selector and operands toward the ula registers
  always_comb begin
    win_sel_s = req_sel0;
    win_a_s   = req_a0;
    win_b_s   = req_b0;
    if (win_s) begin
      win_sel_s = req_sel1;
      win_a_s   = req_a1;
      win_b_s   = req_b1;
    end else begin
      win_sel_s = req_sel0;
      win_a_s   = req_a0;
      win_b_s   = req_b0;
    end
  end

  // Response completion: only the granted requester's resp_ready is looked at
  always_comb begin
    resp_done_s = 1'b0;
    if (state_r == RESP) begin
      resp_done_s = resp_ready[grant_r];
    end else begin
      resp_done_s = 1'b0;
    end
  end

  // Next-state logic: EXEC always lasts exactly one cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      OCIOSO: begin
        if (win_ok_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = OCIOSO;
        end
      end
      EXEC: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (resp_done_s) begin
          state_nxt_s = OCIOSO;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = OCIOSO;
      end
    endcase
  end

  // State, grant owner and round-robin pointer; the pointer moves on every accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= OCIOSO;
      prio_r  <= PRIO_INI;
      grant_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (win_ok_s) begin
        grant_r <= win_s;
        prio_r  <= ~win_s;
      end
    end
  end

  // ula input registers: loaded only on an accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ula_a_r   <= {LARG{1'b0}};
      ula_b_r   <= {LARG{1'b0}};
      ula_sel_r <= 4'b0000;
    end else if (win_ok_s) begin
      ula_a_r   <= win_a_s;
      ula_b_r   <= win_b_s;
      ula_sel_r <= win_sel_s;
    end
  end

  // Response registers: capture at the end of EXEC and hold until the handshake completes
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_s_r     <= {LARG{1'b0}};
      resp_err_r   <= 1'b0;
      resp_valid_r <= 2'b00;
    end else if (state_r == EXEC) begin
      resp_s_r     <= ula_s;
      resp_err_r   <= (ula_sel_r >= SEL_INVALID_MIN);
      resp_valid_r <= port_onehot(grant_r);
    end else if (resp_done_s) begin
      resp_valid_r <= 2'b00;
    end
  end

  assign req_ready  = ready_s;
  assign ula_a      = ula_a_r;
  assign ula_b      = ula_b_r;
  assign ula_sel    = ula_sel_r;
  assign resp_s     = resp_s_r;
  assign resp_err   = resp_err_r;
  assign resp_valid = resp_valid_r;

endmodule
